// File: rtl/mem_pkg.sv
// Shared definitions for the multiport memory: read-collision policy codes,
// clear-sequencer states and the supported port-count range.
package mem_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    localparam int MIN_WR_PORTS = 1;
    localparam int MAX_WR_PORTS = 4;
    localparam int MIN_RD_PORTS = 1;
    localparam int MAX_RD_PORTS = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/multiport_memory_if.sv
// Bundle of the write, read and scan ports of the multiport memory.
// Each port's field sits at [k*WIDTH +: WIDTH] of the packed vectors.
interface multiport_memory_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int N_WR   = 2,
    parameter int N_RD   = 3
);

    logic [N_WR-1:0]        w_en;
    logic [N_WR*ADDR_W-1:0] w_adrs;
    logic [N_WR*DATA_W-1:0] data_in;
    logic [N_WR-1:0]        w_valid;

    logic [N_RD-1:0]        r_en;
    logic [N_RD*ADDR_W-1:0] r_adrs;
    logic [N_RD-1:0]        r_valid;
    logic [N_RD*DATA_W-1:0] data_out;

    logic [ADDR_W-1:0]      scan_adrs;
    logic [DATA_W-1:0]      scan_data;
    logic                   busy;

    modport master (
        output w_en, w_adrs, data_in, r_en, r_adrs, scan_adrs,
        input  w_valid, r_valid, data_out, scan_data, busy
    );

    modport slave (
        input  w_en, w_adrs, data_in, r_en, r_adrs, scan_adrs,
        output w_valid, r_valid, data_out, scan_data, busy
    );

endinterface

// File: rtl/mem_clear_fsm.sv
// Clear sequencer: after reset walks every address once, asking the storage
// to write zero there, and holds busy until the last word is done.
module mem_clear_fsm
    import mem_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_ptr
);

    localparam logic [ADDR_W-1:0] LAST_ADRS = '1;

    state_t state;
    state_t next_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // The pointer wraps to zero on the final clear write, ready for a later restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (clr_ptr == LAST_ADRS) next_state = READY;
            READY:   next_state = READY;
            default: next_state = CLEAR;
        endcase
    end

    always_comb begin
        busy   = (state == CLEAR);
        clr_we = (state == CLEAR) && !reset;
    end

endmodule

// File: rtl/multiport_memory.sv
// Multi-write, multi-read memory with an always-on scan port, a configurable
// read/write collision policy and a self-clearing start-up sequence.
module multiport_memory
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 11,
    parameter int N_WR    = 2,
    parameter int N_RD    = 3,
    parameter int RD_MODE = READ_FIRST
) (
    input  logic                clk,
    input  logic                reset,
    multiport_memory_if.slave   bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_ptr;
    logic              accept;

    logic [ADDR_W-1:0] wr_adrs [N_WR];
    logic [DATA_W-1:0] wr_data [N_WR];
    logic [N_WR-1:0]   wr_fire;
    logic [ADDR_W-1:0] rd_adrs [N_RD];
    logic [DATA_W-1:0] rd_word [N_RD];
    logic [DATA_W-1:0] scan_word;

    logic [N_WR-1:0]   w_valid_q;
    logic [N_RD-1:0]   r_valid_q;
    logic [DATA_W-1:0] rd_q [N_RD];
    logic [DATA_W-1:0] scan_q;

    mem_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk     (clk),
        .reset   (reset),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_ptr (clr_ptr)
    );

    assign accept   = !busy && !reset;
    assign bus.busy = busy;

    for (genvar k = 0; k < N_WR; k++) begin : g_wr_unpack
        assign wr_adrs[k]     = bus.w_adrs[k*ADDR_W +: ADDR_W];
        assign wr_data[k]     = bus.data_in[k*DATA_W +: DATA_W];
    end

    for (genvar j = 0; j < N_RD; j++) begin : g_rd_ports
        assign rd_adrs[j]                      = bus.r_adrs[j*ADDR_W +: ADDR_W];
        assign bus.data_out[j*DATA_W +: DATA_W] = rd_q[j];
    end

    // A write port loses to any lower-index port requesting the same address.
    always_comb begin
        wr_fire = '0;
        for (int k = 0; k < N_WR; k++) begin
            wr_fire[k] = accept && bus.w_en[k];
            for (int i = 0; i < k; i++) begin
                if (bus.w_en[i] && (wr_adrs[i] == wr_adrs[k])) begin
                    wr_fire[k] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        scan_word = mem[bus.scan_adrs];
        for (int j = 0; j < N_RD; j++) begin
            rd_word[j] = mem[rd_adrs[j]];
        end
        if (RD_MODE == WRITE_FIRST) begin
            if (clr_we && (clr_ptr == bus.scan_adrs)) begin
                scan_word = '0;
            end
            for (int k = 0; k < N_WR; k++) begin
                if (wr_fire[k] && (wr_adrs[k] == bus.scan_adrs)) begin
                    scan_word = wr_data[k];
                end
                for (int j = 0; j < N_RD; j++) begin
                    if (wr_fire[k] && (wr_adrs[k] == rd_adrs[j])) begin
                        rd_word[j] = wr_data[k];
                    end
                end
            end
        end
    end

    // Clear writes and port writes never coincide: ports are only accepted when not busy.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_ptr] <= '0;
        end
        for (int k = 0; k < N_WR; k++) begin
            if (wr_fire[k]) begin
                mem[wr_adrs[k]] <= wr_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_valid_q <= '0;
            r_valid_q <= '0;
            scan_q    <= '0;
            for (int j = 0; j < N_RD; j++) begin
                rd_q[j] <= '0;
            end
        end else begin
            w_valid_q <= wr_fire;
            r_valid_q <= bus.r_en & {N_RD{accept}};
            scan_q    <= scan_word;
            for (int j = 0; j < N_RD; j++) begin
                if (bus.r_en[j] && accept) begin
                    rd_q[j] <= rd_word[j];
                end
            end
        end
    end

    assign bus.w_valid   = w_valid_q;
    assign bus.r_valid   = r_valid_q;
    assign bus.scan_data = scan_q;

endmodule

// File: tb/tb_multiport_memory.sv
// Scoreboard bench: one READ_FIRST and one WRITE_FIRST instance share stimulus;
// expectations come from a bench-side memory model.
module tb_multiport_memory;
    import mem_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int N_WR   = 2;
    localparam int N_RD   = 3;
    localparam int DEPTH  = 16;

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [31:0] exp_rf;
        logic [31:0] exp_wf;
    } sb_entry_t;

    logic clk = 1'b0;
    logic reset;

    logic [N_WR-1:0]        w_en;
    logic [N_WR*ADDR_W-1:0] w_adrs;
    logic [N_WR*DATA_W-1:0] data_in;
    logic [N_RD-1:0]        r_en;
    logic [N_RD*ADDR_W-1:0] r_adrs;
    logic [ADDR_W-1:0]      scan_adrs;

    multiport_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_WR(N_WR), .N_RD(N_RD)) bus_rf ();
    multiport_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_WR(N_WR), .N_RD(N_RD)) bus_wf ();

    assign bus_rf.w_en = w_en;       assign bus_wf.w_en = w_en;
    assign bus_rf.w_adrs = w_adrs;   assign bus_wf.w_adrs = w_adrs;
    assign bus_rf.data_in = data_in; assign bus_wf.data_in = data_in;
    assign bus_rf.r_en = r_en;       assign bus_wf.r_en = r_en;
    assign bus_rf.r_adrs = r_adrs;   assign bus_wf.r_adrs = r_adrs;
    assign bus_rf.scan_adrs = scan_adrs;
    assign bus_wf.scan_adrs = scan_adrs;

    multiport_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_WR(N_WR), .N_RD(N_RD),
                       .RD_MODE(READ_FIRST)) dut_rf (
        .clk(clk), .reset(reset), .bus(bus_rf.slave));

    multiport_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_WR(N_WR), .N_RD(N_RD),
                       .RD_MODE(WRITE_FIRST)) dut_wf (
        .clk(clk), .reset(reset), .bus(bus_wf.slave));

    always #5 clk = ~clk;

    int          compared   = 0;
    int          mismatched = 0;
    sb_entry_t   sb_q[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_out_rf [N_RD];
    logic [31:0] model_out_wf [N_RD];
    bit          ready = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] observe(input int kind, input int idx, input bit wf);
        logic [31:0] v;
        v = '0;
        case (kind)
            0: v = wf ? 32'(bus_wf.w_valid) : 32'(bus_rf.w_valid);
            1: v = wf ? 32'(bus_wf.r_valid) : 32'(bus_rf.r_valid);
            2: v = wf ? bus_wf.data_out[idx*DATA_W +: DATA_W] : bus_rf.data_out[idx*DATA_W +: DATA_W];
            default: v = wf ? bus_wf.scan_data : bus_rf.scan_data;
        endcase
        return v;
    endfunction

    task automatic pushExpect(input string tag, input int kind, input int idx,
                              input logic [31:0] exp_rf, input logic [31:0] exp_wf);
        sb_entry_t e;
        e.tag = tag; e.kind = kind; e.idx = idx; e.exp_rf = exp_rf; e.exp_wf = exp_wf;
        sb_q.push_back(e);
    endtask

    task automatic drainScoreboard();
        sb_entry_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput({e.tag, "/rf"}, observe(e.kind, e.idx, 1'b0), e.exp_rf);
            checkOutput({e.tag, "/wf"}, observe(e.kind, e.idx, 1'b1), e.exp_wf);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic startReset();
        reset = 1'b1;
        ready = 1'b0;
        w_en  = '0;
        r_en  = '0;
        for (int j = 0; j < N_RD; j++) begin
            model_out_rf[j] = '0;
            model_out_wf[j] = '0;
        end
    endtask

    // Counts consecutive sampled cycles with busy high on each instance, bounded by max_cycles.
    task automatic countBusy(input int max_cycles, output int n_rf, output int n_wf);
        n_rf = 0;
        n_wf = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (bus_rf.busy !== 1'b1 && bus_wf.busy !== 1'b1) break;
            if (bus_rf.busy === 1'b1) n_rf++;
            if (bus_wf.busy === 1'b1) n_wf++;
            tick();
        end
    endtask

    task automatic applyStimulus(input string tag,
                                 input logic [1:0] we, input logic [3:0] wa0, input logic [3:0] wa1,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [2:0] re, input logic [3:0] ra0, input logic [3:0] ra1,
                                 input logic [3:0] ra2, input logic [3:0] sa);
        logic [3:0]  wa [N_WR];
        logic [31:0] wd [N_WR];
        logic [3:0]  ra [N_RD];
        logic [1:0]  win;
        logic [31:0] fwd;
        wa[0] = wa0; wa[1] = wa1; wd[0] = d0; wd[1] = d1;
        ra[0] = ra0; ra[1] = ra1; ra[2] = ra2;
        w_en = we; w_adrs = {wa1, wa0}; data_in = {d1, d0};
        r_en = re; r_adrs = {ra2, ra1, ra0}; scan_adrs = sa;

        win[0] = we[0];
        win[1] = we[1] && !(we[0] && (wa0 == wa1));
        if (!ready) win = '0;
        pushExpect({tag, ".w_valid"}, 0, 0, 32'(win), 32'(win));
        pushExpect({tag, ".r_valid"}, 1, 0, ready ? 32'(re) : 32'd0, ready ? 32'(re) : 32'd0);

        for (int j = 0; j < N_RD; j++) begin
            if (ready && re[j]) begin
                fwd = model_mem[ra[j]];
                for (int k = 0; k < N_WR; k++) if (win[k] && wa[k] == ra[j]) fwd = wd[k];
                model_out_rf[j] = model_mem[ra[j]];
                model_out_wf[j] = fwd;
            end
            pushExpect($sformatf("%s.data_out%0d", tag, j), 2, j, model_out_rf[j], model_out_wf[j]);
        end
        if (ready) begin
            fwd = model_mem[sa];
            for (int k = 0; k < N_WR; k++) if (win[k] && wa[k] == sa) fwd = wd[k];
            pushExpect({tag, ".scan"}, 3, 0, model_mem[sa], fwd);
        end
        for (int k = 0; k < N_WR; k++) if (win[k]) model_mem[wa[k]] = wd[k];

        tick();
        drainScoreboard();
        w_en = '0;
        r_en = '0;
    endtask

    initial begin
        int n_rf, n_wf, m_rf, m_wf;
        w_adrs = '0; data_in = '0; r_adrs = '0; scan_adrs = '0;
        startReset();
        repeat (2) tick();

        checkOutput("rst.busy_rf", 32'(bus_rf.busy), 32'd1);
        checkOutput("rst.busy_wf", 32'(bus_wf.busy), 32'd1);
        checkOutput("rst.w_valid", 32'(bus_rf.w_valid | bus_wf.w_valid), 32'd0);
        checkOutput("rst.r_valid", 32'(bus_rf.r_valid | bus_wf.r_valid), 32'd0);
        for (int j = 0; j < N_RD; j++) begin
            checkOutput($sformatf("rst.data_out%0d", j), observe(2, j, 1'b0) | observe(2, j, 1'b1), 32'd0);
        end
        checkOutput("rst.scan", bus_rf.scan_data | bus_wf.scan_data, 32'd0);

        reset = 1'b0;
        countBusy(100, n_rf, n_wf);
        checkOutput("clear.busy_cycles_rf", 32'(n_rf), 32'd16);
        checkOutput("clear.busy_cycles_wf", 32'(n_wf), 32'd16);
        ready = 1'b1;
        for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;

        for (int a = 0; a < DEPTH; a += 3) begin
            applyStimulus("clear.read", 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 3'b111,
                          4'(a), 4'((a + 1) % DEPTH), 4'((a + 2) % DEPTH), 4'(a));
        end

        applyStimulus("wr5", 2'b01, 4'd5, 4'd0, 32'hDEADBEEF, 32'd0, 3'b000, 4'd0, 4'd0, 4'd0, 4'd0);
        applyStimulus("rd5", 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 3'b100, 4'd0, 4'd0, 4'd5, 4'd5);

        applyStimulus("coll3", 2'b11, 4'd3, 4'd3, 32'h11, 32'h22, 3'b000, 4'd0, 4'd0, 4'd0, 4'd0);
        applyStimulus("rd3", 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 3'b001, 4'd3, 4'd0, 4'd0, 4'd3);

        applyStimulus("wr7a", 2'b01, 4'd7, 4'd0, 32'hA, 32'd0, 3'b000, 4'd0, 4'd0, 4'd0, 4'd0);
        applyStimulus("rw7", 2'b01, 4'd7, 4'd0, 32'hB, 32'd0, 3'b001, 4'd7, 4'd0, 4'd0, 4'd7);
        applyStimulus("rd7", 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 3'b010, 4'd0, 4'd7, 4'd0, 4'd7);

        applyStimulus("wr9", 2'b10, 4'd0, 4'd9, 32'd0, 32'h55, 3'b000, 4'd0, 4'd0, 4'd0, 4'd0);
        applyStimulus("rd9x3", 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 3'b111, 4'd9, 4'd9, 4'd9, 4'd9);

        for (int i = 0; i < 24; i++) begin
            applyStimulus("rand", 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                          4'($urandom_range(0, 3)), $urandom, $urandom, 3'($urandom_range(0, 7)),
                          4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
        end

        // Reset reasserted part way through a clear restarts it from address 0.
        startReset();
        tick();
        reset = 1'b0;
        countBusy(8, n_rf, n_wf);
        checkOutput("reclear.first_part_rf", 32'(n_rf), 32'd8);
        startReset();
        tick();
        checkOutput("reclear.rst_busy", 32'(bus_rf.busy & bus_wf.busy), 32'd1);
        reset = 1'b0;
        countBusy(10, n_rf, n_wf);
        applyStimulus("busy_wr", 2'b01, 4'd2, 4'd0, 32'h77, 32'd0, 3'b001, 4'd2, 4'd0, 4'd0, 4'd2);
        countBusy(100, m_rf, m_wf);
        checkOutput("reclear.busy_cycles_rf", 32'(n_rf + 1 + m_rf), 32'd16);
        checkOutput("reclear.busy_cycles_wf", 32'(n_wf + 1 + m_wf), 32'd16);
        ready = 1'b1;
        for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
        applyStimulus("rd_after", 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 3'b111, 4'd2, 4'd5, 4'd9, 4'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multiport_memory.md
MULTIPORT_MEMORY -- requirements
Module: multiport_memory

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 11, meaning address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter N_WR, default 2, meaning number of write ports (1..4).
REQ-004 The block SHALL have parameter N_RD, default 3, meaning number of read ports (1..8).
REQ-005 The block SHALL have parameter RD_MODE, default READ_FIRST, meaning same-cycle read/write collision policy (READ_FIRST or WRITE_FIRST).
REQ-006 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-008 The block SHALL have port w_en, input, N_WR, the per-port write request.
REQ-009 The block SHALL have port w_adrs, input, N_WR*ADDR_W, the per-port write address; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port data_in, input, N_WR*DATA_W, the per-port write data, packed the same way.
REQ-011 The block SHALL have port w_valid, output, N_WR, the per-port write-accepted pulse.
REQ-012 The block SHALL have port r_en, input, N_RD, the per-port read request.
REQ-013 The block SHALL have port r_adrs, input, N_RD*ADDR_W, the per-port read address.
REQ-014 The block SHALL have port r_valid, output, N_RD, the per-port read-data-valid pulse.
REQ-015 The block SHALL have port data_out, output, N_RD*DATA_W, the per-port read data.
REQ-016 The block SHALL have port scan_adrs, input, ADDR_W, the display/scan read address, which is always enabled.
REQ-017 The block SHALL have port scan_data, output, DATA_W, the scan read data.
REQ-018 The block SHALL have port busy, output, 1, which is high while the memory-clear sequence runs.

Function
REQ-019 The block SHALL have two states, CLEAR and READY; reset forces CLEAR with clr_ptr=0.
REQ-020 In CLEAR with reset low, the block SHALL write 0 to mem[clr_ptr] each cycle and increment clr_ptr; at clr_ptr==DEPTH-1 it goes to READY on the next edge.
REQ-021 busy SHALL equal (state==CLEAR); busy falls exactly DEPTH cycles after the first edge with reset low.
REQ-022 Reset asserted mid-clear SHALL restart the clear at address 0.
REQ-023 While busy, all w_en and r_en requests SHALL be dropped, with no memory write, w_valid=0 and r_valid=0.
REQ-024 In READY, for each write port k with w_en[k]=1, the block SHALL write data_in[k] to mem[w_adrs[k]] at the edge and assert w_valid[k] for the following cycle.
REQ-025 On a write-address collision between ports, the lowest-index port SHALL win; every losing port gets w_valid=0 and its data is discarded.
REQ-026 Read latency SHALL be 1: with r_en[j]=1 at edge N, data_out[j]=mem[r_adrs[j]] and r_valid[j]=1 during cycle N+1.
REQ-027 When r_en[j]=0, r_valid[j] SHALL be 0 and data_out[j] SHALL hold its previous value.
REQ-028 On a read and write to the same address in the same cycle, READ_FIRST SHALL return the old word and WRITE_FIRST SHALL return the winning write data.
REQ-029 scan_data SHALL be updated from mem[scan_adrs] every cycle with latency 1, including during CLEAR, and SHALL follow the RD_MODE collision policy.
REQ-030 Multiple read ports addressing the same word SHALL each receive the same data.

Reset
REQ-031 While reset is high, the block SHALL drive w_valid=0, r_valid=0, data_out=0, scan_data=0, busy=1 and state=CLEAR; memory contents are zeroed only by the clear sequence.

Structure
REQ-032 Package mem_pkg SHALL hold the RD_MODE encodings (READ_FIRST=0, WRITE_FIRST=1), the state enum {CLEAR, READY} and the port-count limits.
REQ-033 The clear state machine, clr_ptr counter and busy output SHALL be one sub-module, mem_clear_fsm; the storage array and port logic stay in the top module.

Verification (bench parameters: ADDR_W=4, DATA_W=32, N_WR=2, N_RD=3)
REQ-034 Scenario: pulse reset for 1 cycle, then release -> busy=1 for exactly 16 cycles; a subsequent read of addresses 0..15 returns 0.
REQ-035 Scenario: write port0 0xDEADBEEF to address 5, then read port2 address 5 -> w_valid[0] pulses once; next cycle data_out[2]=0xDEADBEEF with r_valid[2]=1.
REQ-036 Scenario: in the same cycle, port0 writes 0x11 and port1 writes 0x22 to address 3 -> mem[3]=0x11, w_valid=2'b01.
REQ-037 Scenario: address 7 holds 0xA, then write 0xB to address 7 while reading address 7 -> READ_FIRST returns 0xA; WRITE_FIRST returns 0xB.
REQ-038 Scenario: reset reasserted at clear cycle 8 -> busy stays high for another 16 cycles after release; a write issued during busy is not stored and gives w_valid=0.
REQ-039 Scenario: all 3 read ports read address 9 holding 0x55 -> all data_out=0x55 and r_valid=3'b111; scan_adrs=9 gives scan_data=0x55.
